bus_xfer_sequencer: RTL

//  Driver side of the 24-source datapath bus mux. Queues bus-transfer commands (source index,

---
 rtl/bus_xfer_sequencer_if.sv | 25 ++
 rtl/bus_xfer_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bus_xfer_sequencer_if.sv
// Command/enable bundle between the control unit (master) and the bus
// transfer sequencer (slave).
interface bus_xfer_sequencer_if #(
  parameter int LEN_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_src;
  logic [4:0]       cmd_dst;
  logic [LEN_W-1:0] cmd_len;
  logic [23:0]      out_en;
  logic [24:0]      dst_en;
  logic             busy;
  logic             err;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_len,
    input  cmd_ready, out_en, dst_en, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len,
    output cmd_ready, out_en, dst_en, busy, err
  );
endinterface

// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: queues {src,dst,len} bus-transfer commands and replays
// each as a one-hot source out-enable (held len+1 cycles) plus a one-hot
// destination in-enable in the final cycle. Outputs decode registered state only.
// Optional feature: define BUSSEQ_CMD_CHECK_EN to drop illegal commands at the
// handshake and raise a sticky err flag.
module bus_xfer_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 2
) (
  input logic                 clock,
  input logic                 clear,
  bus_xfer_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]       src;
    logic [4:0]       dst;
    logic [LEN_W-1:0] len;
  } cmd_t;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t           state, stateNxt;
  cmd_t             mem [DEPTH];
  cmd_t             cur;
  cmd_t             cmdIn;
  logic [LEN_W-1:0] cnt;
  logic [AW:0]      wrPtr, rdPtr;
  logic             full, empty, accept, push, pop;
  logic [23:0]      outEn;
  logic [24:0]      dstEn;

  // Extra pointer MSB separates full from empty when the low bits match.
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  assign bus.cmd_ready = !full;
  assign accept        = bus.cmd_valid && !full;
  assign cmdIn         = '{src: bus.cmd_src, dst: bus.cmd_dst, len: bus.cmd_len};

`ifdef BUSSEQ_CMD_CHECK_EN
  logic cmdLegal;
  logic errR;

  // Illegal commands complete the handshake but never reach the FIFO.
  assign cmdLegal = (bus.cmd_src <= 5'd23) && !((bus.cmd_dst >= 5'd25) && (bus.cmd_dst <= 5'd30));
  assign push     = accept && cmdLegal;
  assign bus.err  = errR;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (clear)                  errR <= 1'b0;
    else if (accept && !cmdLegal) errR <= 1'b1;
  end
`else
  assign push    = accept;
  assign bus.err = 1'b0;
`endif

  // FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr[AW-1:0]] <= cmdIn;
  end

  // FIFO pointers; push and pop may occur in the same cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= stateNxt;
  end

  // Current transfer and remaining hold count; a pop reloads both.
  always_ff @(posedge clock) begin
    if (clear) begin
      cur <= '0;
      cnt <= '0;
    end else if (pop) begin
      cur <= mem[rdPtr[AW-1:0]];
      cnt <= mem[rdPtr[AW-1:0]].len;
    end else if (state == DRIVE && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Next state, pop decision and Moore enable decode.
  always_comb begin
    stateNxt = state;
    pop      = 1'b0;
    outEn    = '0;
    dstEn    = '0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          stateNxt = DRIVE;
        end
      end
      DRIVE: begin
        // Source index i maps to bus-mux bit 23-i; out-of-range sources drive nothing.
        if (cur.src <= 5'd23) outEn = 24'h800000 >> cur.src;
        if (cnt == '0) begin
          if (cur.dst <= 5'd24) dstEn = 25'd1 << cur.dst;
          // Chain straight into the next command so len=0 streams run one per cycle.
          if (!empty) pop = 1'b1;
          else        stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign bus.out_en = outEn;
  assign bus.dst_en = dstEn;
  assign bus.busy   = (state == DRIVE) || !empty;
endmodule
